tdoa_detect: RTL and testbench
==============================

Name: tdoa_detect

Overview:
- Consumes each 3-channel sample group produced by the synchronous ADC sampler, one group per 40 kHz strobe.
- Detects the arrival of an acoustic echo on each microphone by comparing the absolute deviation from mid-scale against a programmable threshold.
- Reports per-channel arrival delays, in samples, relative to the first channel that fired. This is the time-difference-of-arrival used for localisation.
- Sits between the sampler and the STM32 link serializer, and hands off events over a valid/ready handshake.

Parameters:
- N_ADC, 3, number of microphone channels
- W_ADC, 12, ADC resolution; sample data occupies bits [W_ADC-1:0] of each word
- W_ADC_WORD, 16, width of each sample word
- W_TS, 16, width of the free-running sample counter
- WINDOW, 400, capture window in samples (10 ms at 40 kHz); must be >= 2
- HOLDOFF, 4000, samples ignored after an event is accepted (0 = re-arm immediately)

Ports:
- clk  in  1  fabric clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- en  in  1  detector enable; low forces the idle/armed state
- thresh  in  W_ADC  deviation threshold; strictly-greater comparison
- sample_valid  in  1  one-cycle strobe; all sample words are valid this cycle
- sample0/sample1/sample2  in  W_ADC_WORD each  channel samples; upper W_ADC_WORD-W_ADC bits are ignored
- evt_valid  out  1  event available; held until accepted
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready
- evt_time  out  W_TS  sample-counter value at the first crossing
- evt_dly0/evt_dly1/evt_dly2  out  clog2(WINDOW) each  arrival offset in samples from the first crossing
- evt_mask  out  N_ADC  bit i set if channel i crossed inside the window
- evt_timeout  out  1  window expired before all channels crossed
- busy  out  1  state != S_ARMED

Behaviour:
- Reset: all outputs 0, state S_ARMED, all counters 0.
- Sample counter: increments on every sample_valid regardless of state; wraps from 2^W_TS-1 to 0.
- Crossing, channel i: dev_i = |s_i[W_ADC-1:0] - 2^(W_ADC-1)|, computed at W_ADC+1 bits; crossed_i = dev_i > thresh. Evaluated only when sample_valid=1.
- S_ARMED, on sample_valid with any crossed_i:
  - Capture evt_time = current counter value, before its increment.
  - mask = crossed; dly of each crossed channel = 0; win_cnt = 1.
  - If mask is all ones, go to S_REPORT with timeout=0. Otherwise go to S_CAPTURE.
- S_CAPTURE, on each sample_valid (k = win_cnt):
  - Each channel not yet in mask that crosses gets dly = k and its mask bit set. Already-set channels are never overwritten.
  - If mask is all ones, go to S_REPORT with timeout=0.
  - Otherwise, if k == WINDOW-1, go to S_REPORT with timeout=1; missing channels keep dly=0 and mask bit 0.
  - Otherwise win_cnt++.
- S_REPORT:
  - evt_valid=1; all evt_* outputs stable.
  - sample_valid is ignored for detection.
  - On evt_valid && evt_ready: drop evt_valid the next cycle, clear the holdoff counter, then go to S_HOLDOFF. If HOLDOFF=0, go to S_ARMED instead.
- S_HOLDOFF: count sample_valid; when the count reaches HOLDOFF, go to S_ARMED. Crossings during holdoff are ignored.
- Latency: evt_valid rises on the cycle after the sample_valid that completes capture.
- en=0: next cycle state = S_ARMED, evt_valid=0, and any partial capture is discarded. Last evt_* data may remain on the outputs; it is not valid.
- A sample_valid coinciding with a state transition is consumed by the state in which it arrived.
- Reset mid-operation: immediate return to the reset values on the next edge.

Decomposition:
- Package echo_pkg: N_ADC, W_ADC, W_ADC_WORD, MIDSCALE = 2^(W_ADC-1), state encodings S_ARMED/S_CAPTURE/S_REPORT/S_HOLDOFF.
- Sub-module thresh_cmp, instantiated once per channel: combinational abs-deviation and compare.

Test Plan:
- Reset: assert rst for 5 cycles mid-capture -> all outputs 0, busy=0, next crossing is treated as a first crossing.
- Staggered arrival: thresh=200; ch0=2348 at counter 10, ch1=1748 at 13, ch2=2300 at 17 -> evt_valid one cycle after sample 17; evt_time=10, dly=0/3/7, mask=111, timeout=0.
- Boundary compare plus simultaneous arrival:
  - thresh=200, ch0=2248 (dev exactly 200) -> no detect.
  - All channels at 2049+200 on the same sample -> direct to S_REPORT; dly=0/0/0, mask=111.
- Timeout: ch0 and ch2 cross, ch1 silent -> evt_valid after sample k=399; mask=101, dly1=0, timeout=1.
- Backpressure and holdoff: hold evt_ready=0 for 50 cycles -> outputs stable throughout. After accept, crossings on the next 4000 samples are ignored; a crossing on sample 4001 is detected.
- Wrap and enable:
  - First crossing at counter 65535 -> evt_time=65535 and later delays are correct across the wrap.
  - Drop en mid-capture -> S_ARMED next cycle, no event emitted.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared constants, state encoding and helpers for the echo arrival detector.
package echo_pkg;

    localparam int N_ADC      = 3;
    localparam int W_ADC      = 12;
    localparam int W_ADC_WORD = 16;

    // Mid-scale code of the unipolar ADC, held at W_ADC+1 bits so that the
    // deviation arithmetic never overflows.
    localparam logic [W_ADC:0] MIDSCALE = {2'b01, {(W_ADC-1){1'b0}}};

    typedef enum logic [1:0] {
        S_ARMED   = 2'd0,
        S_CAPTURE = 2'd1,
        S_REPORT  = 2'd2,
        S_HOLDOFF = 2'd3
    } state_e;

    // True once every microphone channel has reported an arrival.
    function automatic logic all_set(input logic [N_ADC-1:0] mask);
        return &mask;
    endfunction

endpackage

// File: rtl/thresh_cmp.sv
// Per-channel crossing detector: |sample - mid-scale| > threshold.
module thresh_cmp
    import echo_pkg::*;
(
    input  logic [W_ADC_WORD-1:0] sample,
    input  logic [W_ADC-1:0]      thresh,
    output logic                  crossed
);

    logic [W_ADC:0] mag_s;
    logic [W_ADC:0] dev_s;
    logic           unused_hi_s;

    // Upper word bits carry no sample data.
    assign unused_hi_s = ^sample[W_ADC_WORD-1:W_ADC];
    assign mag_s       = {1'b0, sample[W_ADC-1:0]};

    // Absolute deviation from mid-scale, never negative.
    always_comb begin
        dev_s = '0;
        if (mag_s >= MIDSCALE) begin
            dev_s = mag_s - MIDSCALE;
        end else begin
            dev_s = MIDSCALE - mag_s;
        end
    end

    // Strictly-greater: a deviation equal to the threshold is not an arrival.
    assign crossed = (dev_s > {1'b0, thresh});

endmodule

// File: rtl/tdoa_detect.sv
// Time-difference-of-arrival detector: timestamps the first channel to cross
// the threshold and measures the other channels' delays in samples.
module tdoa_detect
    import echo_pkg::*;
#(
    parameter  int W_TS    = 16,
    parameter  int WINDOW  = 400,
    parameter  int HOLDOFF = 4000,
    localparam int W_DLY   = $clog2(WINDOW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [W_ADC-1:0]      thresh,
    input  logic                  sample_valid,
    input  logic [W_ADC_WORD-1:0] sample0,
    input  logic [W_ADC_WORD-1:0] sample1,
    input  logic [W_ADC_WORD-1:0] sample2,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [W_TS-1:0]       evt_time,
    output logic [W_DLY-1:0]      evt_dly0,
    output logic [W_DLY-1:0]      evt_dly1,
    output logic [W_DLY-1:0]      evt_dly2,
    output logic [N_ADC-1:0]      evt_mask,
    output logic                  evt_timeout,
    output logic                  busy
);

    localparam int W_HOLD = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [W_DLY-1:0]  WIN_LAST  = W_DLY'(WINDOW - 1);
    localparam logic [W_HOLD-1:0] HOLD_LAST = W_HOLD'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

    logic [W_ADC_WORD-1:0] sample_s [N_ADC];
    logic [N_ADC-1:0]      crossed_s;

    state_e                state_r,   state_nx_s;
    logic [W_TS-1:0]       cnt_r;
    logic [W_DLY-1:0]      win_cnt_r, win_nx_s;
    logic [W_HOLD-1:0]     hold_cnt_r, hold_nx_s;
    logic [W_TS-1:0]       time_r,    time_nx_s;
    logic [N_ADC-1:0]      mask_r,    mask_nx_s;
    logic                  timeout_r, timeout_nx_s;
    logic [W_DLY-1:0]      dly_r      [N_ADC];
    logic [W_DLY-1:0]      dly_nx_s   [N_ADC];
    logic                  evt_valid_r;
    logic                  busy_r;

    assign sample_s[0] = sample0;
    assign sample_s[1] = sample1;
    assign sample_s[2] = sample2;

    for (genvar g = 0; g < N_ADC; g++) begin : g_cmp
        thresh_cmp u_cmp (
            .sample  (sample_s[g]),
            .thresh  (thresh),
            .crossed (crossed_s[g])
        );
    end

    // Next-state and capture datapath; en low discards any capture in flight.
    always_comb begin
        state_nx_s   = state_r;
        win_nx_s     = win_cnt_r;
        hold_nx_s    = hold_cnt_r;
        time_nx_s    = time_r;
        mask_nx_s    = mask_r;
        timeout_nx_s = timeout_r;
        for (int i = 0; i < N_ADC; i++) begin
            dly_nx_s[i] = dly_r[i];
        end

        if (!en) begin
            state_nx_s = S_ARMED;
        end else begin
            case (state_r)
                S_ARMED: begin
                    if (sample_valid && (|crossed_s)) begin
                        time_nx_s    = cnt_r;
                        mask_nx_s    = crossed_s;
                        win_nx_s     = W_DLY'(1);
                        timeout_nx_s = 1'b0;
                        for (int i = 0; i < N_ADC; i++) begin
                            dly_nx_s[i] = '0;
                        end
                        if (all_set(crossed_s)) begin
                            state_nx_s = S_REPORT;
                        end else begin
                            state_nx_s = S_CAPTURE;
                        end
                    end else begin
                        state_nx_s = S_ARMED;
                    end
                end
                S_CAPTURE: begin
                    if (sample_valid) begin
                        mask_nx_s = mask_r | crossed_s;
                        // Only first arrivals are recorded; later crossings
                        // on an already-seen channel are echoes of no interest.
                        for (int i = 0; i < N_ADC; i++) begin
                            if (crossed_s[i] && !mask_r[i]) begin
                                dly_nx_s[i] = win_cnt_r;
                            end else begin
                                dly_nx_s[i] = dly_r[i];
                            end
                        end
                        if (all_set(mask_r | crossed_s)) begin
                            state_nx_s   = S_REPORT;
                            timeout_nx_s = 1'b0;
                        end else if (win_cnt_r == WIN_LAST) begin
                            state_nx_s   = S_REPORT;
                            timeout_nx_s = 1'b1;
                        end else begin
                            win_nx_s = win_cnt_r + W_DLY'(1);
                        end
                    end else begin
                        state_nx_s = S_CAPTURE;
                    end
                end
                S_REPORT: begin
                    if (evt_ready) begin
                        hold_nx_s = '0;
                        if (HOLDOFF == 0) begin
                            state_nx_s = S_ARMED;
                        end else begin
                            state_nx_s = S_HOLDOFF;
                        end
                    end else begin
                        state_nx_s = S_REPORT;
                    end
                end
                S_HOLDOFF: begin
                    if (sample_valid) begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            state_nx_s = S_ARMED;
                        end else begin
                            hold_nx_s = hold_cnt_r + W_HOLD'(1);
                        end
                    end else begin
                        state_nx_s = S_HOLDOFF;
                    end
                end
                default: begin
                    state_nx_s = S_ARMED;
                end
            endcase
        end
    end

    // State, counters and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_ARMED;
            cnt_r       <= '0;
            win_cnt_r   <= '0;
            hold_cnt_r  <= '0;
            time_r      <= '0;
            mask_r      <= '0;
            timeout_r   <= 1'b0;
            evt_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < N_ADC; i++) begin
                dly_r[i] <= '0;
            end
        end else begin
            state_r     <= state_nx_s;
            win_cnt_r   <= win_nx_s;
            hold_cnt_r  <= hold_nx_s;
            time_r      <= time_nx_s;
            mask_r      <= mask_nx_s;
            timeout_r   <= timeout_nx_s;
            evt_valid_r <= (state_nx_s == S_REPORT);
            busy_r      <= (state_nx_s != S_ARMED);
            for (int i = 0; i < N_ADC; i++) begin
                dly_r[i] <= dly_nx_s[i];
            end
            if (sample_valid) begin
                cnt_r <= cnt_r + W_TS'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign evt_valid   = evt_valid_r;
    assign evt_time    = time_r;
    assign evt_dly0    = dly_r[0];
    assign evt_dly1    = dly_r[1];
    assign evt_dly2    = dly_r[2];
    assign evt_mask    = mask_r;
    assign evt_timeout = timeout_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_tdoa_detect.sv
// Directed bench for tdoa_detect with hand-computed expected values.
module tb_tdoa_detect;

    localparam int W_TS  = 16;
    localparam int W_DLY = $clog2(400);
    localparam logic [15:0] Q = 16'd2048;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [11:0]       thresh;
    logic              sample_valid;
    logic [15:0]       sample0, sample1, sample2;
    logic              evt_valid;
    logic              evt_ready;
    logic [W_TS-1:0]   evt_time;
    logic [W_DLY-1:0]  evt_dly0, evt_dly1, evt_dly2;
    logic [2:0]        evt_mask;
    logic              evt_timeout;
    logic              busy;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] cnt_exp;
    logic [15:0] last_cnt;
    logic [15:0] t0;
    logic        flag;

    tdoa_detect #(.W_TS(16), .WINDOW(400), .HOLDOFF(4000)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .thresh       (thresh),
        .sample_valid (sample_valid),
        .sample0      (sample0),
        .sample1      (sample1),
        .sample2      (sample2),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_time     (evt_time),
        .evt_dly0     (evt_dly0),
        .evt_dly1     (evt_dly1),
        .evt_dly2     (evt_dly2),
        .evt_mask     (evt_mask),
        .evt_timeout  (evt_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic smp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        last_cnt     = cnt_exp;
        cnt_exp      = cnt_exp + 16'd1;
        sample0      = a;
        sample1      = b;
        sample2      = c;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        sample0      = Q;
        sample1      = Q;
        sample2      = Q;
    endtask

    task automatic chk_evt(input string tag, input logic [15:0] t, input logic [8:0] d0,
                           input logic [8:0] d1, input logic [8:0] d2,
                           input logic [2:0] m, input logic to);
        chk({tag, "_valid"},   32'(evt_valid),   32'd1);
        chk({tag, "_time"},    32'(evt_time),    32'(t));
        chk({tag, "_dly0"},    32'(evt_dly0),    32'(d0));
        chk({tag, "_dly1"},    32'(evt_dly1),    32'(d1));
        chk({tag, "_dly2"},    32'(evt_dly2),    32'(d2));
        chk({tag, "_mask"},    32'(evt_mask),    32'(m));
        chk({tag, "_timeout"}, 32'(evt_timeout), 32'(to));
    endtask

    // Accept the pending event, then drop en for one cycle to skip the holdoff.
    task automatic release_evt();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; thresh = 12'd200; sample_valid = 1'b0;
        sample0 = Q; sample1 = Q; sample2 = Q; evt_ready = 1'b0;
        cnt_exp = 16'd0; last_cnt = 16'd0; t0 = 16'd0; flag = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_mask",  32'(evt_mask),  32'd0);
        chk("rst_time",  32'(evt_time),  32'd0);

        // Deviation exactly equal to the threshold, either side, and upper junk bits.
        smp(16'd2248, Q, Q);
        chk("bound_hi_busy", 32'(busy), 32'd0);
        smp(16'd1848, Q, Q);
        chk("bound_lo_busy", 32'(busy), 32'd0);
        smp(16'hF800, 16'hF800, 16'hF800);
        chk("upper_bits_busy", 32'(busy), 32'd0);

        // Staggered arrival: ch0 at 10, ch1 at 13, ch2 at 17.
        while (cnt_exp != 16'd10) smp(Q, Q, Q);
        smp(16'd2348, Q, Q);
        chk("stag_first_busy",  32'(busy),      32'd1);
        chk("stag_first_valid", 32'(evt_valid), 32'd0);
        smp(Q, Q, Q); smp(Q, Q, Q);
        smp(Q, 16'd1748, Q);
        smp(Q, Q, Q); smp(Q, Q, Q); smp(Q, Q, Q);
        chk("stag_16_valid", 32'(evt_valid), 32'd0);
        smp(Q, Q, 16'd2300);
        chk_evt("stag", 16'd10, 9'd0, 9'd3, 9'd7, 3'b111, 1'b0);

        // Backpressure: hold the event for 50 cycles while crossings keep arriving.
        flag = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i % 2 == 0) smp(16'd2348, 16'd2348, 16'd2348);
            else tick();
            if (!(evt_valid === 1'b1 && evt_time === 16'd10 && evt_dly0 === 9'd0 &&
                  evt_dly1 === 9'd3 && evt_dly2 === 9'd7 && evt_mask === 3'b111 &&
                  evt_timeout === 1'b0)) flag = 1'b0;
        end
        chk("bp_stable", 32'(flag), 32'd1);

        // Accept, then holdoff of 4000 samples all crossing.
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("acc_valid", 32'(evt_valid), 32'd0);
        chk("acc_busy",  32'(busy),      32'd1);
        flag = 1'b0;
        for (int j = 1; j <= 4000; j++) begin
            smp(16'd2249, 16'd2249, 16'd2249);
            if (evt_valid) flag = 1'b1;
            if (j == 3999) chk("hold_3999_busy", 32'(busy), 32'd1);
            if (j == 4000) chk("hold_4000_busy", 32'(busy), 32'd0);
        end
        chk("hold_no_evt", 32'(flag), 32'd0);
        // Sample 4001, simultaneous arrival on all channels at dev 201.
        smp(16'd2249, 16'd2249, 16'd2249);
        chk_evt("simul", last_cnt, 9'd0, 9'd0, 9'd0, 3'b111, 1'b0);
        release_evt();

        // Timeout: ch0 at k=0, ch2 at k=5, ch1 never.
        smp(16'd2348, Q, Q);
        t0 = last_cnt;
        for (int k = 1; k <= 399; k++) begin
            smp(Q, Q, (k == 5) ? 16'd2348 : Q);
            if (k == 398) begin
                chk("to_398_valid", 32'(evt_valid), 32'd0);
                chk("to_398_busy",  32'(busy),      32'd1);
            end
        end
        chk_evt("timeout", t0, 9'd0, 9'd0, 9'd5, 3'b101, 1'b1);
        release_evt();

        // Enable drop mid-capture discards the partial capture.
        smp(Q, 16'd2348, Q);
        chk("en_cap_busy", 32'(busy), 32'd1);
        en = 1'b0;
        tick();
        en = 1'b1;
        chk("en_drop_busy",  32'(busy),      32'd0);
        chk("en_drop_valid", 32'(evt_valid), 32'd0);
        smp(Q, Q, Q); smp(Q, Q, Q); smp(Q, Q, Q);
        chk("en_quiet_valid", 32'(evt_valid), 32'd0);
        chk("en_quiet_busy",  32'(busy),      32'd0);
        smp(Q, Q, 16'd2348);
        t0 = last_cnt;
        smp(16'd2348, 16'd2348, Q);
        chk_evt("en_fresh", t0, 9'd1, 9'd1, 9'd0, 3'b111, 1'b0);
        release_evt();

        // Reset held 5 cycles mid-capture.
        smp(16'd2348, Q, Q);
        chk("rst_cap_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (5) tick();
        chk("rst2_valid",   32'(evt_valid),   32'd0);
        chk("rst2_busy",    32'(busy),        32'd0);
        chk("rst2_mask",    32'(evt_mask),    32'd0);
        chk("rst2_time",    32'(evt_time),    32'd0);
        chk("rst2_dly0",    32'(evt_dly0),    32'd0);
        chk("rst2_timeout", 32'(evt_timeout), 32'd0);
        rst = 1'b0;
        cnt_exp = 16'd0;
        smp(Q, 16'd2348, Q);
        chk("rst_first_busy", 32'(busy), 32'd1);
        smp(16'd2348, Q, 16'd2348);
        chk_evt("rst_first", 16'd0, 9'd1, 9'd0, 9'd1, 3'b111, 1'b0);
        release_evt();

        // Counter wrap: first crossing at 65535, later ones after the wrap.
        while (cnt_exp != 16'hFFFF) smp(Q, Q, Q);
        smp(16'd2348, Q, Q);
        smp(Q, Q, Q);
        smp(Q, 16'd1748, Q);
        smp(Q, Q, 16'd2300);
        chk_evt("wrap", 16'hFFFF, 9'd0, 9'd2, 9'd3, 3'b111, 1'b0);
        release_evt();
        smp(16'd2249, 16'd2249, 16'd2249);
        chk_evt("post_wrap", 16'd3, 9'd0, 9'd0, 9'd0, 3'b111, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
